// File: rtl/lcd_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_timing_gen: pixel-request / DE / HS / VS timing for parallel LCDs.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd_timing_gen #(
    parameter int   P_H_SYNC   = 128,
    parameter int   P_H_BACK   = 88,
    parameter int   P_H_DISP   = 800,
    parameter int   P_H_FRONT  = 40,
    parameter int   P_V_SYNC   = 2,
    parameter int   P_V_BACK   = 33,
    parameter int   P_V_DISP   = 480,
    parameter int   P_V_FRONT  = 10,
    parameter int   P_CNT_W    = 11,
    parameter int   P_DATA_W   = 24,
    parameter int   P_REQ_LEAD = 2,     // legal 1..4
    parameter int   P_MODE     = 0,     // 0 = DE-only, 1 = HV sync
    parameter logic P_HS_POL   = 1'b0,
    parameter logic P_VS_POL   = 1'b0
) (
    input  logic                i_lcd_pclk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic [P_DATA_W-1:0] i_pixel_data,
    output logic [P_CNT_W-1:0]  o_pixel_xpos,
    output logic [P_CNT_W-1:0]  o_pixel_ypos,
    output logic                o_data_req,
    output logic                o_frame_start,
    output logic                o_busy,
    output logic                o_lcd_de,
    output logic                o_lcd_hs,
    output logic                o_lcd_vs,
    output logic                o_lcd_bl,
    output logic                o_lcd_clk,
    output logic                o_lcd_rst,
    output logic [P_DATA_W-1:0] o_lcd_rgb
);

    localparam logic [P_CNT_W-1:0] C_H_LAST = P_CNT_W'(P_H_SYNC + P_H_BACK + P_H_DISP + P_H_FRONT - 1);
    localparam logic [P_CNT_W-1:0] C_V_LAST = P_CNT_W'(P_V_SYNC + P_V_BACK + P_V_DISP + P_V_FRONT - 1);
    localparam logic [P_CNT_W-1:0] C_H_BEG  = P_CNT_W'(P_H_SYNC + P_H_BACK);
    localparam logic [P_CNT_W-1:0] C_H_END  = P_CNT_W'(P_H_SYNC + P_H_BACK + P_H_DISP);
    localparam logic [P_CNT_W-1:0] C_V_BEG  = P_CNT_W'(P_V_SYNC + P_V_BACK);
    localparam logic [P_CNT_W-1:0] C_V_END  = P_CNT_W'(P_V_SYNC + P_V_BACK + P_V_DISP);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_STOP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [P_CNT_W-1:0]    h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [P_CNT_W-1:0]    xpos_q, ypos_q;
    logic                  fs_q;
    logic [P_REQ_LEAD-1:0] de_pipe_q;
    logic                  lcd_de_q;
    logic [P_DATA_W-1:0]   rgb_q;
    logic                  w_busy, w_last, w_req;

    assign w_last = (h_cnt_q == C_H_LAST) && (v_cnt_q == C_V_LAST);
    assign w_req  = w_busy && (h_cnt_q >= C_H_BEG) && (h_cnt_q < C_H_END)
                           && (v_cnt_q >= C_V_BEG) && (v_cnt_q < C_V_END);

    always_ff @(posedge i_lcd_pclk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= C_ST_IDLE;
        else          state_q <= state_d;
    end

    // Stopping lets the current frame finish; the last count exits straight to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: if (i_en) state_d = C_ST_RUN;
            C_ST_RUN:  if (!i_en) state_d = w_last ? C_ST_IDLE : C_ST_STOP;
            C_ST_STOP: begin
                if (i_en)        state_d = C_ST_RUN;
                else if (w_last) state_d = C_ST_IDLE;
            end
            default:   state_d = C_ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        case (state_q)
            C_ST_RUN, C_ST_STOP: w_busy = 1'b1;
            default:             w_busy = 1'b0;
        endcase
    end

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!w_busy) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == C_H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == C_V_LAST) ? '0 : v_cnt_q + 1'b1;
        end else begin
            h_cnt_d = h_cnt_q + 1'b1;
        end
    end

    // de_pipe_q[0] is the request itself; the last stage marks the cycle its pixel arrives.
    always_ff @(posedge i_lcd_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            xpos_q    <= '0;
            ypos_q    <= '0;
            fs_q      <= 1'b0;
            de_pipe_q <= '0;
            lcd_de_q  <= 1'b0;
            rgb_q     <= '0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            xpos_q       <= w_req ? h_cnt_q - C_H_BEG : '0;
            ypos_q       <= w_req ? v_cnt_q - C_V_BEG : '0;
            fs_q         <= w_req && (h_cnt_q == C_H_BEG) && (v_cnt_q == C_V_BEG);
            de_pipe_q[0] <= w_req;
            for (int k = 1; k < P_REQ_LEAD; k++) de_pipe_q[k] <= de_pipe_q[k-1];
            lcd_de_q     <= de_pipe_q[P_REQ_LEAD-1];
            rgb_q        <= de_pipe_q[P_REQ_LEAD-1] ? i_pixel_data : '0;
        end
    end

    generate
        if (P_MODE == 1) begin : g_hv_mode
            localparam logic [P_CNT_W-1:0] C_H_SYNC = P_CNT_W'(P_H_SYNC);
            localparam logic [P_CNT_W-1:0] C_V_SYNC = P_CNT_W'(P_V_SYNC);
            logic [P_REQ_LEAD-1:0] hs_pipe_q, vs_pipe_q;
            logic                  hs_act_q, vs_act_q;
            logic                  w_hs_raw, w_vs_raw;

            assign w_hs_raw = w_busy && (h_cnt_q < C_H_SYNC);
            assign w_vs_raw = w_busy && (v_cnt_q < C_V_SYNC);

            always_ff @(posedge i_lcd_pclk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    hs_pipe_q <= '0;
                    vs_pipe_q <= '0;
                    hs_act_q  <= 1'b0;
                    vs_act_q  <= 1'b0;
                end else begin
                    hs_pipe_q[0] <= w_hs_raw;
                    vs_pipe_q[0] <= w_vs_raw;
                    for (int k = 1; k < P_REQ_LEAD; k++) begin
                        hs_pipe_q[k] <= hs_pipe_q[k-1];
                        vs_pipe_q[k] <= vs_pipe_q[k-1];
                    end
                    hs_act_q <= hs_pipe_q[P_REQ_LEAD-1];
                    vs_act_q <= vs_pipe_q[P_REQ_LEAD-1];
                end
            end

            assign o_lcd_hs = hs_act_q ? P_HS_POL : ~P_HS_POL;
            assign o_lcd_vs = vs_act_q ? P_VS_POL : ~P_VS_POL;
        end else begin : g_de_mode
            assign o_lcd_hs = 1'b1;
            assign o_lcd_vs = 1'b1;
        end
    endgenerate

    assign o_pixel_xpos  = xpos_q;
    assign o_pixel_ypos  = ypos_q;
    assign o_data_req    = de_pipe_q[0];
    assign o_frame_start = fs_q;
    assign o_busy        = w_busy;
    assign o_lcd_bl      = w_busy;
    assign o_lcd_de      = lcd_de_q;
    assign o_lcd_rgb     = rgb_q;
    assign o_lcd_clk     = i_lcd_pclk;
    assign o_lcd_rst     = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lcd_timing_gen: scoreboard bench on a 10x6 timing, HV and DE modes.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lcd_timing_gen;
    localparam int CW = 11;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] pix = '0;

    logic [CW-1:0] xpos, ypos, xpos_b, ypos_b;
    logic          req, fs, busy, de, hs, vs, bl, lclk, lrst;
    logic          req_b, fs_b, busy_b, de_b, hs_b, vs_b, bl_b, lclk_b, lrst_b;
    logic [DW-1:0] rgb, rgb_b;

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .P_H_SYNC(2), .P_H_BACK(2), .P_H_DISP(4), .P_H_FRONT(2),
        .P_V_SYNC(1), .P_V_BACK(1), .P_V_DISP(3), .P_V_FRONT(1),
        .P_CNT_W(CW), .P_DATA_W(DW), .P_REQ_LEAD(2), .P_MODE(1),
        .P_HS_POL(1'b0), .P_VS_POL(1'b0)
    ) dut (
        .i_lcd_pclk(clk), .i_rst_n(rst_n), .i_en(en), .i_pixel_data(pix),
        .o_pixel_xpos(xpos), .o_pixel_ypos(ypos), .o_data_req(req),
        .o_frame_start(fs), .o_busy(busy), .o_lcd_de(de), .o_lcd_hs(hs),
        .o_lcd_vs(vs), .o_lcd_bl(bl), .o_lcd_clk(lclk), .o_lcd_rst(lrst),
        .o_lcd_rgb(rgb)
    );

    lcd_timing_gen #(
        .P_H_SYNC(2), .P_H_BACK(2), .P_H_DISP(4), .P_H_FRONT(2),
        .P_V_SYNC(1), .P_V_BACK(1), .P_V_DISP(3), .P_V_FRONT(1),
        .P_CNT_W(CW), .P_DATA_W(DW), .P_REQ_LEAD(2), .P_MODE(0),
        .P_HS_POL(1'b0), .P_VS_POL(1'b0)
    ) dut_de (
        .i_lcd_pclk(clk), .i_rst_n(rst_n), .i_en(en), .i_pixel_data(pix),
        .o_pixel_xpos(xpos_b), .o_pixel_ypos(ypos_b), .o_data_req(req_b),
        .o_frame_start(fs_b), .o_busy(busy_b), .o_lcd_de(de_b), .o_lcd_hs(hs_b),
        .o_lcd_vs(vs_b), .o_lcd_bl(bl_b), .o_lcd_clk(lclk_b), .o_lcd_rst(lrst_b),
        .o_lcd_rgb(rgb_b)
    );

    typedef struct {int val; int cyc;} exp_t;
    exp_t sb[$];
    exp_t e;

    int checks = 0, errors = 0;
    int cyc = 0;
    int ref_x = 0, ref_y = 0;
    int pend = -1;
    logic hs_prev = 1'b1, vs_prev = 1'b1;
    int hs_fall = 0, vs_fall = 0;
    bit hs_ok = 1'b0, vs_ok = 1'b0;
    bit exp_fs;

    // Pixel source, coordinate model and scoreboard, all sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        cyc++;
        pix  = (pend >= 0) ? DW'(pend) : DW'($urandom);
        pend = -1;
        exp_fs = req && ref_x == 0 && ref_y == 0;
        checks++;
        if (fs !== exp_fs) begin
            errors++; $display("FAIL frame_start cyc %0d: got %b want %b", cyc, fs, exp_fs);
        end
        checks++;
        if (req) begin
            if (xpos !== CW'(ref_x) || ypos !== CW'(ref_y)) begin
                errors++; $display("FAIL coord: got (%0d,%0d) want (%0d,%0d)", xpos, ypos, ref_x, ref_y);
            end
            pend = ref_x + 16 * ref_y;
            sb.push_back('{pend, cyc + 2});
            ref_x++;
            if (ref_x == 4) begin ref_x = 0; ref_y = (ref_y == 2) ? 0 : ref_y + 1; end
        end else if (xpos !== '0 || ypos !== '0) begin
            errors++; $display("FAIL idle_coord: got (%0d,%0d) want (0,0)", xpos, ypos);
        end
        checks++;
        if (de) begin
            if (sb.size() == 0) begin
                errors++; $display("FAIL de_unexpected: de=1 with no request pending");
            end else begin
                e = sb.pop_front();
                if (rgb !== DW'(e.val) || cyc != e.cyc) begin
                    errors++; $display("FAIL pixel: got rgb %0d at cyc %0d want %0d at cyc %0d", rgb, cyc, e.val, e.cyc);
                end
                if (e.val % 16 == 0 && hs_ok) begin
                    checks++;
                    if (cyc - hs_fall != 4) begin
                        errors++; $display("FAIL hs_align: got %0d want 4", cyc - hs_fall);
                    end
                end
                if (e.val == 0 && vs_ok) begin
                    checks++;
                    if (cyc - vs_fall != 24) begin
                        errors++; $display("FAIL vs_align: got %0d want 24", cyc - vs_fall);
                    end
                end
            end
        end else if (rgb !== '0) begin
            errors++; $display("FAIL rgb_blank: got %0d want 0", rgb);
        end
        checks++;
        if (hs_b !== 1'b1 || vs_b !== 1'b1 || de_b !== de || rgb_b !== rgb) begin
            errors++; $display("FAIL de_mode: got hs %b vs %b de %b rgb %0d want 1 1 %b %0d",
                               hs_b, vs_b, de_b, rgb_b, de, rgb);
        end
        if (hs_prev && !hs) begin hs_fall = cyc; hs_ok = 1'b1; end
        if (!hs_prev && hs && hs_ok) begin
            checks++;
            if (cyc - hs_fall != 2) begin
                errors++; $display("FAIL hs_width: got %0d want 2", cyc - hs_fall);
            end
        end
        if (vs_prev && !vs) begin vs_fall = cyc; vs_ok = 1'b1; end
        if (!vs_prev && vs && vs_ok) begin
            checks++;
            if (cyc - vs_fall != 10) begin
                errors++; $display("FAIL vs_width: got %0d want 10", cyc - vs_fall);
            end
        end
        hs_prev = hs;
        vs_prev = vs;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_fs(output int n, output bit found);
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 100 && !found; i++) begin
            tick();
            if (fs) begin found = 1'b1; n = i; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en = 1'b0;
        repeat (3) tick();
        checks++;
        if ({req, de, fs, busy, bl} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {req, de, fs, busy, bl});
        end
        checks++;
        if (rgb !== '0 || hs !== 1'b1 || vs !== 1'b1) begin
            errors++; $display("FAIL reset_out: got rgb %0d hs %b vs %b want 0 1 1", rgb, hs, vs);
        end
        checks++;
        if (lrst !== 1'b1 || lclk !== clk) begin
            errors++; $display("FAIL reset_pins: got rst %b clk %b want 1 %b", lrst, lclk, clk);
        end
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (busy !== 1'b0 || req !== 1'b0) begin
            errors++; $display("FAIL idle_hold: got busy %b req %b want 0 0", busy, req);
        end
    endtask

    task automatic test_frames;
        int n, reqs, hs_lo, vs_lo, de_hi, gap;
        bit found;
        en = 1'b1;
        wait_fs(n, found);
        checks++;
        if (!found || n != 26) begin
            errors++; $display("FAIL first_req_latency: got %0d want 26", n);
        end
        reqs = 0; hs_lo = 0; vs_lo = 0; de_hi = 0; gap = 0; found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            reqs  += int'(req);
            hs_lo += int'(!hs);
            vs_lo += int'(!vs);
            de_hi += int'(de);
            tick();
            gap++;
            if (fs) found = 1'b1;
        end
        checks++;
        if (!found || gap != 60 || reqs != 12) begin
            errors++; $display("FAIL frame_period: got gap %0d reqs %0d want 60 12", gap, reqs);
        end
        checks++;
        if (hs_lo != 12 || vs_lo != 10 || de_hi != 12) begin
            errors++; $display("FAIL sync_counts: got hs %0d vs %0d de %0d want 12 10 12", hs_lo, vs_lo, de_hi);
        end
    endtask

    task automatic test_en_drop;
        int reqs, extra;
        bit idle;
        reqs = 0; idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            if (req) reqs++;
            if (req && xpos == 1 && ypos == 1) en = 1'b0;
            if (!busy) idle = 1'b1;
            else tick();
        end
        checks++;
        if (!idle || reqs != 12) begin
            errors++; $display("FAIL en_drop_frame: got idle %b reqs %0d want 1 12", idle, reqs);
        end
        checks++;
        if (busy !== 1'b0 || bl !== 1'b0) begin
            errors++; $display("FAIL en_drop_idle: got busy %b bl %b want 0 0", busy, bl);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            extra += int'(req);
        end
        checks++;
        if (extra != 0 || hs !== 1'b1 || vs !== 1'b1 || de !== 1'b0) begin
            errors++; $display("FAIL idle_drained: got reqs %0d hs %b vs %b de %b want 0 1 1 0", extra, hs, vs, de);
        end
    endtask

    task automatic test_en_pulse;
        int n, reqs, gap;
        bit found, dropped;
        en = 1'b1;
        wait_fs(n, found);
        checks++;
        if (!found || n != 26) begin
            errors++; $display("FAIL restart_latency: got %0d want 26", n);
        end
        reqs = 0; gap = 0; found = 1'b0; dropped = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            reqs += int'(req);
            if (!busy) dropped = 1'b1;
            if (gap == 10) en = 1'b0;
            if (gap == 13) en = 1'b1;
            tick();
            gap++;
            if (fs) found = 1'b1;
        end
        checks++;
        if (!found || gap != 60 || reqs != 12 || dropped) begin
            errors++; $display("FAIL en_pulse: got gap %0d reqs %0d busy_drop %b want 60 12 0", gap, reqs, dropped);
        end
    endtask

    task automatic test_reset_midline;
        int n;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (req && xpos == 2 && ypos == 1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL midline_wait: got no (2,1) request want one");
        end
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        checks++;
        if ({req, de, fs, busy, bl} !== 5'b0 || rgb !== '0 || hs !== 1'b1 || vs !== 1'b1
            || xpos !== '0 || ypos !== '0) begin
            errors++; $display("FAIL midline_reset: got ctrl %b rgb %0d hs %b vs %b x %0d y %0d want 00000 0 1 1 0 0",
                               {req, de, fs, busy, bl}, rgb, hs, vs, xpos, ypos);
        end
        sb.delete();
        ref_x = 0; ref_y = 0; pend = -1;
        hs_ok = 1'b0; vs_ok = 1'b0; hs_prev = 1'b1; vs_prev = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got busy %b want 0", busy);
        end
        en = 1'b1;
        wait_fs(n, found);
        checks++;
        if (!found || n != 26 || xpos !== '0 || ypos !== '0) begin
            errors++; $display("FAIL post_reset_frame: got n %0d at (%0d,%0d) want 26 at (0,0)", n, xpos, ypos);
        end
        repeat (40) tick();
    endtask

    initial begin
        test_reset();
        test_frames();
        test_en_drop();
        test_en_pulse();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
